mac_accumulator: RTL and testbench

Processing-element stage that sits directly upstream of the core's result `register` bank. Consumes a stream of operand pairs (row element of A, column element of B) and accumulates their products over `dim_k` beats. Presents the finished dot product on a valid/ready handshake. Also emits a one-cycle `result_we` pulse, so the result drives a downstream `register` through its `dataIn`/`write_en` ports with no glue logic.

---
 rtl/mac_accumulator_if.sv | 29 ++
 rtl/mac_accumulator.sv | 92 +++++++++
 tb/tb_mac_accumulator.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mac_accumulator_if.sv
// rtl/mac_accumulator_if.sv - operand/result handshake bundle for mac_accumulator
interface mac_accumulator_if #(
  parameter int width     = 8,
  parameter int acc_width = 24,
  parameter int k_width   = 8
);
  logic                 start;
  logic [k_width-1:0]   dim_k;
  logic [width-1:0]     a_in;
  logic [width-1:0]     b_in;
  logic                 in_valid;
  logic                 in_ready;
  logic [acc_width-1:0] result;
  logic                 result_valid;
  logic                 result_ready;
  logic                 result_we;
  logic                 busy;
  logic                 overflow;

  modport master (
    output start, dim_k, a_in, b_in, in_valid, result_ready,
    input  in_ready, result, result_valid, result_we, busy, overflow
  );

  modport slave (
    input  start, dim_k, a_in, b_in, in_valid, result_ready,
    output in_ready, result, result_valid, result_we, busy, overflow
  );
endinterface

// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - unsigned dot-product accumulator feeding a result register
// Optional MAC_SATURATE_EN clamps the accumulator to all-ones on overflow instead of wrapping.
module mac_accumulator #(
  parameter int width     = 8,
  parameter int acc_width = 24,
  parameter int k_width   = 8
) (
  input  logic            clk,
  input  logic            rst,
  mac_accumulator_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [k_width-1:0] k_one = 1;

  state_t               state, state_nx;
  logic [acc_width-1:0] acc, acc_nx;
  logic [k_width-1:0]   cnt, dim_q;
  logic                 ovf;
  logic                 beat, last_beat;
  logic [2*width-1:0]   prod;
  logic [acc_width:0]   sum;
  logic                 in_ready_d, result_valid_d, busy_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    in_ready_d     = 1'b0;
    result_valid_d = 1'b0;
    busy_d         = 1'b1;
    case (state)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.start) state_nx = (bus.dim_k == '0) ? DONE : ACCUM;
      end
      ACCUM: begin
        in_ready_d = 1'b1;
        if (beat && last_beat) state_nx = DONE;
      end
      DONE: begin
        result_valid_d = 1'b1;
        if (bus.result_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Beat qualification uses the registered state so in_ready stays input-independent.
  assign beat      = bus.in_valid && (state == ACCUM);
  assign last_beat = (cnt == dim_q - k_one);
  assign prod      = {{width{1'b0}}, bus.a_in} * {{width{1'b0}}, bus.b_in};
  assign sum       = {1'b0, acc} + {{(acc_width + 1 - 2*width){1'b0}}, prod};

  always_comb begin
`ifdef MAC_SATURATE_EN
    acc_nx = sum[acc_width] ? {acc_width{1'b1}} : sum[acc_width-1:0];
`else
    acc_nx = sum[acc_width-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc   <= '0;
      cnt   <= '0;
      dim_q <= '0;
      ovf   <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      acc   <= '0;
      cnt   <= '0;
      dim_q <= bus.dim_k;
      ovf   <= 1'b0;
    end else if (beat) begin
      acc <= acc_nx;
      cnt <= cnt + k_one;
      if (sum[acc_width]) ovf <= 1'b1;
    end
  end

  assign bus.in_ready     = in_ready_d;
  assign bus.result_valid = result_valid_d;
  assign bus.busy         = busy_d;
  assign bus.result       = acc;
  assign bus.overflow     = ovf;
  assign bus.result_we    = result_valid_d & bus.result_ready;

endmodule

// File: tb/tb_mac_accumulator.sv
// tb/tb_mac_accumulator.sv - scoreboard bench for mac_accumulator (24-bit and 16-bit accumulators)
module tb_mac_accumulator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start, in_valid, result_ready;
  logic [7:0] dim_k, a_in, b_in;

  mac_accumulator_if #(.width(8), .acc_width(24), .k_width(8)) bw ();
  mac_accumulator_if #(.width(8), .acc_width(16), .k_width(8)) bn ();

  assign bw.start = start;        assign bn.start = start;
  assign bw.dim_k = dim_k;        assign bn.dim_k = dim_k;
  assign bw.a_in = a_in;          assign bn.a_in = a_in;
  assign bw.b_in = b_in;          assign bn.b_in = b_in;
  assign bw.in_valid = in_valid;  assign bn.in_valid = in_valid;
  assign bw.result_ready = result_ready;
  assign bn.result_ready = result_ready;

  mac_accumulator #(.width(8), .acc_width(24), .k_width(8)) dut_w (.clk(clk), .rst(rst), .bus(bw));
  mac_accumulator #(.width(8), .acc_width(16), .k_width(8)) dut_n (.clk(clk), .rst(rst), .bus(bn));

  typedef struct {
    longint res;
    bit     ov;
  } exp_t;

  exp_t       qw[$], qn[$];
  logic [7:0] pa[$], pb[$];
  int         n_cmp = 0;
  int         n_err = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Reference: plain integer sum of products, then apply the width limit.
  function automatic exp_t model(int aw);
    exp_t   e;
    longint lim;
    longint s;
    lim   = longint'(1) << aw;
    e.res = 0;
    e.ov  = 1'b0;
    foreach (pa[i]) begin
      s = e.res + longint'(pa[i]) * longint'(pb[i]);
      if (s >= lim) begin
        e.ov = 1'b1;
`ifdef MAC_SATURATE_EN
        e.res = lim - 1;
`else
        e.res = s % lim;
`endif
      end else begin
        e.res = s;
      end
    end
    return e;
  endfunction

  logic        hold_w = 1'b0, hold_n = 1'b0;
  logic [23:0] prev_w;
  logic [15:0] prev_n;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      check("we_w", bw.result_we, bw.result_valid & result_ready);
      check("we_n", bn.result_we, bn.result_valid & result_ready);
      if (hold_w && bw.result_valid) check("hold_w", bw.result, prev_w);
      if (hold_n && bn.result_valid) check("hold_n", bn.result, prev_n);
      if (bw.result_valid && result_ready) begin
        if (qw.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL spurious_w: got result %0d expected none", bw.result);
        end else begin
          e = qw.pop_front();
          check("result_w", bw.result, e.res);
          check("ovf_w", bw.overflow, e.ov);
        end
      end
      if (bn.result_valid && result_ready) begin
        if (qn.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL spurious_n: got result %0d expected none", bn.result);
        end else begin
          e = qn.pop_front();
          check("result_n", bn.result, e.res);
          check("ovf_n", bn.overflow, e.ov);
        end
      end
      hold_w = bw.result_valid & ~result_ready;
      hold_n = bn.result_valid & ~result_ready;
      prev_w = bw.result;
      prev_n = bn.result;
    end else begin
      hold_w = 1'b0;
      hold_n = 1'b0;
    end
  end

  task automatic run_txn(input int abort_at, input int stall, input int bp);
    int k;
    int s;
    int b;
    k = pa.size();
    @(posedge clk); #1;
    start = 1'b1;
    dim_k = k[7:0];
    if (abort_at < 0) begin
      qw.push_back(model(24));
      qn.push_back(model(16));
    end
    @(posedge clk); #1;
    start = 1'b0;
    dim_k = 8'($urandom);
    @(negedge clk);
    check("busy_after_start", bw.busy, 1'b1);
    check("in_ready_after_start", bw.in_ready, k != 0);
    for (int i = 0; i < k; i++) begin
      s = (i == 0) ? 0 : ((stall >= 0) ? stall : $urandom_range(0, 3));
      repeat (s) begin
        in_valid = 1'b0;
        start    = 1'($urandom_range(0, 1));
        a_in     = 8'($urandom);
        b_in     = 8'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      start    = 1'($urandom_range(0, 1));
      a_in     = pa[i];
      b_in     = pb[i];
      @(posedge clk); #1;
      in_valid = 1'b0;
      start    = 1'b0;
      if (i == abort_at) begin
        rst = 1'b0;
        #1;
        check("abort_result_w", bw.result, 0);
        check("abort_result_n", bn.result, 0);
        check("abort_busy", bw.busy, 1'b0);
        check("abort_in_ready", bw.in_ready, 1'b0);
        check("abort_ovf", bn.overflow, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        return;
      end
    end
    @(negedge clk);
    check("valid_latency_w", bw.result_valid, 1'b1);
    check("valid_latency_n", bn.result_valid, 1'b1);
    check("in_ready_done", bw.in_ready, 1'b0);
    b = (bp >= 0) ? bp : $urandom_range(0, 4);
    repeat (b) begin
      result_ready = 1'b0;
      start        = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    result_ready = 1'b1;
    start        = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    result_ready = 1'b0;
    start        = 1'b0;
    @(negedge clk);
    check("idle_after_handshake_w", bw.busy, 1'b0);
    check("idle_after_handshake_n", bn.busy, 1'b0);
  endtask

  initial begin
    int k;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; result_ready = 1'b0;
    dim_k = '0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset_result", bw.result, 0);
    check("reset_valid", bw.result_valid, 1'b0);
    check("reset_in_ready", bw.in_ready, 1'b0);
    check("reset_busy", bw.busy, 1'b0);
    check("reset_ovf", bw.overflow, 1'b0);
    check("reset_we", bw.result_we, 1'b0);

    pa = '{8'd2, 8'd4, 8'd10};  pb = '{8'd3, 8'd5, 8'd1};    run_txn(-1, 0, 0);
    pa = '{8'd255, 8'd1};       pb = '{8'd255, 8'd1};        run_txn(-1, 3, 4);
    pa.delete(); pb.delete();                                  run_txn(-1, 0, 2);
    pa = '{8'd255, 8'd255};     pb = '{8'd255, 8'd255};      run_txn(-1, 0, 0);
    pa = '{8'd1, 8'd2, 8'd3, 8'd4}; pb = '{8'd5, 8'd6, 8'd7, 8'd8}; run_txn(0, 0, 0);
    pa = '{8'd7};               pb = '{8'd6};                run_txn(-1, 0, 1);

    repeat (40) begin
      k = $urandom_range(0, 8);
      pa.delete(); pb.delete();
      repeat (k) begin
        pa.push_back(($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom));
        pb.push_back(($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom));
      end
      run_txn(-1, -1, -1);
    end

    pa.delete(); pb.delete();
    repeat (255) begin
      pa.push_back(8'd255);
      pb.push_back(8'd255);
    end
    run_txn(-1, 0, 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("drained_w", qw.size(), 0);
    check("drained_n", qn.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
